// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] data;
    logic            filled;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] a);
    return a & ~PC_W'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch buffer: slots allocated on request accept, filled in order by
// memory responses, popped in order by decode.
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_alloc,
  input  logic [PC_W-1:0]        i_alloc_pc,
  input  logic                   i_fill,
  input  logic [PC_W-1:0]        i_fill_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [$clog2(DEPTH):0] o_unfilled
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_alloc_ptr;
  logic [AW-1:0]   r_fill_ptr;
  logic [AW-1:0]   r_pop_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_unfilled;

  assign o_head     = r_mem[r_pop_ptr];
  assign o_count    = r_count;
  assign o_unfilled = r_unfilled;

  // Pointer slots never collide: alloc hits a free slot, fill an unfilled one, pop a filled one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || i_flush) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_pop_ptr   <= '0;
      r_count     <= '0;
      r_unfilled  <= '0;
    end else begin
      if (i_alloc) begin
        r_mem[r_alloc_ptr] <= '{pc: i_alloc_pc, data: '0, filled: 1'b0};
        r_alloc_ptr        <= r_alloc_ptr + AW'(1);
      end
      if (i_fill) begin
        r_mem[r_fill_ptr].data   <= i_fill_data;
        r_mem[r_fill_ptr].filled <= 1'b1;
        r_fill_ptr               <= r_fill_ptr + AW'(1);
      end
      if (i_pop) begin
        r_mem[r_pop_ptr].filled <= 1'b0;
        r_pop_ptr               <= r_pop_ptr + AW'(1);
      end
      r_count    <= r_count + CW'(i_alloc) - CW'(i_pop);
      r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: fetch PC, imem request/response tracking, redirect flush.
// Optional IFU_MISALIGN_EN: misaligned redirect halts fetch and presents one flagged nop.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [PC_W-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [PC_W-1:0] inst,
  output logic [PC_W-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc
`ifdef IFU_MISALIGN_EN
  ,
  output logic            inst_misaligned
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = 8;

  logic [PC_W-1:0] r_fetch_pc;
  logic [DW-1:0]   r_discard_cnt;

  fetch_entry_t    w_head;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_unfilled;
  logic            w_accept;
  logic            w_alloc;
  logic            w_fill;
  logic            w_pop;
  logic            w_halted;

  assign imem_req  = !rst && (w_count < CW'(DEPTH)) && !w_halted;
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_ready;
  assign w_alloc   = w_accept && !redirect_valid;
  // Responses owed to flushed requests are dropped before any slot is filled.
  assign w_fill    = imem_rvalid && !redirect_valid && (r_discard_cnt == '0) && (w_unfilled != '0);
  assign w_pop     = w_head.filled && inst_ready;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .i_alloc     (w_alloc),
    .i_alloc_pc  (r_fetch_pc),
    .i_fill      (w_fill),
    .i_fill_data (imem_rdata),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_unfilled  (w_unfilled)
  );

  // Redirect turns every accepted-but-unanswered request into a pending discard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_discard_cnt <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= pc_align(redirect_pc);
      r_discard_cnt <= r_discard_cnt + DW'(w_unfilled) + DW'(w_accept) - DW'(imem_rvalid);
    end else begin
      if (w_accept) r_fetch_pc <= r_fetch_pc + PC_W'(4);
      if (imem_rvalid && (r_discard_cnt != '0)) r_discard_cnt <= r_discard_cnt - DW'(1);
    end
  end

`ifdef IFU_MISALIGN_EN
  logic            r_halted;
  logic            r_mis_pending;
  logic [PC_W-1:0] r_mis_pc;
  logic            w_mis_valid;

  assign w_halted        = r_halted;
  assign w_mis_valid     = r_halted && r_mis_pending && (w_count == '0);
  assign inst_valid      = w_head.filled || w_mis_valid;
  assign inst            = w_mis_valid ? NOP_INST : w_head.data;
  assign inst_pc         = w_mis_valid ? r_mis_pc : w_head.pc;
  assign inst_misaligned = w_mis_valid;

  // Halt lasts until the next redirect; the flagged nop is presented exactly once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halted      <= 1'b0;
      r_mis_pending <= 1'b0;
      r_mis_pc      <= '0;
    end else if (redirect_valid) begin
      r_halted      <= |redirect_pc[1:0];
      r_mis_pending <= |redirect_pc[1:0];
      r_mis_pc      <= redirect_pc;
    end else if (w_mis_valid && inst_ready) begin
      r_mis_pending <= 1'b0;
    end
  end
`else
  assign w_halted   = 1'b0;
  assign inst_valid = w_head.filled;
  assign inst       = w_head.data;
  assign inst_pc    = w_head.pc;
`endif

`ifndef SYNTHESIS
  a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> ((r_discard_cnt != '0) || (w_unfilled != '0)));
`endif

endmodule
